// File: rtl/f2o_pkg.sv
// f2o_pkg: shared types, constants and helpers for the FIFO read-side drain
package f2o_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} drain_state_t;
    localparam int OUT_SLOTS = 2;
    function automatic logic [1:0] sat2(input logic [31:0] n);
        return n >= 32'd2 ? 2'd2 : n[1:0];
    endfunction
endpackage

// File: rtl/f2o_slot_ctrl.sv
// f2o_slot_ctrl: occupancy state, accept count and FIFO pop count for the 2-slot stage
module f2o_slot_ctrl
    import f2o_pkg::*;
#(
    parameter int NUM_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ready0,
    input  logic             ready1,
    input  logic [NUM_W-1:0] fifo_num,
    output drain_state_t     state,
    output logic [1:0]       k,
    output logic [1:0]       remain,
    output logic [1:0]       take,
    output logic             rd_first,
    output logic             rd_second
);
    drain_state_t nxt;
    logic [1:0] cnt, free, avail;
    logic acc0, acc1;
    always_ff @(posedge clk)
        state <= rst ? EMPTY : nxt;
    always_comb begin
        cnt = state;
        acc0 = state != EMPTY && ready0;
        acc1 = acc0 && state == TWO && ready1;
        k = {1'b0, acc0} + {1'b0, acc1};
        remain = cnt - k;
        free = 2'(OUT_SLOTS) - remain;
        avail = sat2(32'(fifo_num));
        take = (rst || flush) ? 2'd0 : (free < avail ? free : avail);
        nxt = flush ? EMPTY : drain_state_t'(remain + take);
        rd_first = take != 2'd0;
        rd_second = take == 2'd2;
    end
endmodule

// File: rtl/f2o_drain.sv
// f2o_drain: in-order 0/1/2-per-cycle FIFO drain into a 2-lane registered output stage (F2O_DRAIN_PERF_EN adds perf counters)
module f2o_drain
    import f2o_pkg::*;
#(
    parameter int FIFO_SIZE_WIDTH = 5,
    parameter int FIFO_DATA_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic [FIFO_SIZE_WIDTH:0]   fifo_num_i,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_rdata_first_i,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_rdata_second_i,
    output logic                       fifo_rd_first_en_o,
    output logic                       fifo_rd_second_en_o,
    output logic                       out_valid0_o,
    output logic                       out_valid1_o,
    output logic [FIFO_DATA_WIDTH-1:0] out_data0_o,
    output logic [FIFO_DATA_WIDTH-1:0] out_data1_o,
`ifdef F2O_DRAIN_PERF_EN
    output logic [31:0]                perf_pop_cnt_o,
    output logic [31:0]                perf_stall_cnt_o,
`endif
    input  logic                       out_ready0_i,
    input  logic                       out_ready1_i
);
    drain_state_t state;
    logic [1:0] k, remain, take;
    logic [FIFO_DATA_WIDTH-1:0] nxt0, nxt1;
    f2o_slot_ctrl #(.NUM_W(FIFO_SIZE_WIDTH + 1)) u_ctrl (
        .clk(clk),
        .rst(rst),
        .flush(flush_i),
        .ready0(out_ready0_i),
        .ready1(out_ready1_i),
        .fifo_num(fifo_num_i),
        .state(state),
        .k(k),
        .remain(remain),
        .take(take),
        .rd_first(fifo_rd_first_en_o),
        .rd_second(fifo_rd_second_en_o)
    );
    assign out_valid0_o = state != EMPTY;
    assign out_valid1_o = state == TWO;
    // survivor shifts into slot0 first, popped entries fill behind it in FIFO order
    always_comb begin
        nxt0 = remain == 2'd1 ? (k == 2'd1 ? out_data1_o : out_data0_o)
             : (remain == 2'd0 && take != 2'd0) ? fifo_rdata_first_i : out_data0_o;
        nxt1 = remain == 2'd1 ? (take != 2'd0 ? fifo_rdata_first_i : out_data1_o)
             : (remain == 2'd0 && take == 2'd2) ? fifo_rdata_second_i : out_data1_o;
    end
    always_ff @(posedge clk) begin
        out_data0_o <= rst ? '0 : nxt0;
        out_data1_o <= rst ? '0 : nxt1;
    end
`ifdef F2O_DRAIN_PERF_EN
    always_ff @(posedge clk) begin
        perf_pop_cnt_o <= rst ? 32'd0 : perf_pop_cnt_o + 32'(take);
        perf_stall_cnt_o <= rst ? 32'd0
                          : perf_stall_cnt_o + 32'(state == TWO && !out_ready0_i);
    end
`endif
endmodule

// File: tb/tb_f2o_drain.sv
// tb_f2o_drain: directed self-checking bench for f2o_drain
module tb_f2o_drain;
    logic clk = 1'b0;
    logic rst, flush_i, out_ready0_i, out_ready1_i;
    logic [5:0] fifo_num_i;
    logic [4:0] fifo_rdata_first_i, fifo_rdata_second_i;
    logic fifo_rd_first_en_o, fifo_rd_second_en_o, out_valid0_o, out_valid1_o;
    logic [4:0] out_data0_o, out_data1_o;
`ifdef F2O_DRAIN_PERF_EN
    logic [31:0] perf_pop_cnt_o, perf_stall_cnt_o;
`endif
    int checks = 0;
    int failures = 0;

    f2o_drain dut (
        .clk(clk),
        .rst(rst),
        .flush_i(flush_i),
        .fifo_num_i(fifo_num_i),
        .fifo_rdata_first_i(fifo_rdata_first_i),
        .fifo_rdata_second_i(fifo_rdata_second_i),
        .fifo_rd_first_en_o(fifo_rd_first_en_o),
        .fifo_rd_second_en_o(fifo_rd_second_en_o),
        .out_valid0_o(out_valid0_o),
        .out_valid1_o(out_valid1_o),
        .out_data0_o(out_data0_o),
        .out_data1_o(out_data1_o),
`ifdef F2O_DRAIN_PERF_EN
        .perf_pop_cnt_o(perf_pop_cnt_o),
        .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
        .out_ready0_i(out_ready0_i),
        .out_ready1_i(out_ready1_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] num, input logic [4:0] d0, input logic [4:0] d1,
                         input logic r0, input logic r1);
        fifo_num_i = num;
        fifo_rdata_first_i = d0;
        fifo_rdata_second_i = d1;
        out_ready0_i = r0;
        out_ready1_i = r1;
        #1;
    endtask

    task automatic pops(input string tag, input logic e0, input logic e1);
        chk({tag, ".rd0"}, 32'(fifo_rd_first_en_o), 32'(e0));
        chk({tag, ".rd1"}, 32'(fifo_rd_second_en_o), 32'(e1));
    endtask

    task automatic lanes(input string tag, input logic v0, input logic v1,
                         input logic [4:0] d0, input logic [4:0] d1);
        chk({tag, ".v0"}, 32'(out_valid0_o), 32'(v0));
        chk({tag, ".v1"}, 32'(out_valid1_o), 32'(v1));
        if (v0) chk({tag, ".d0"}, 32'(out_data0_o), 32'(d0));
        if (v1) chk({tag, ".d1"}, 32'(out_data1_o), 32'(d1));
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        drive(6'd4, 5'h0A, 5'h0B, 1'b1, 1'b1);
        pops("rst_hold", 1'b0, 1'b0);
        tick();
        tick();
        lanes("rst", 1'b0, 1'b0, 5'h0, 5'h0);
        chk("rst.d0", 32'(out_data0_o), 32'h0);
        chk("rst.d1", 32'(out_data1_o), 32'h0);

        rst = 1'b0;
        drive(6'd4, 5'h0A, 5'h0B, 1'b1, 1'b1);
        pops("ab", 1'b1, 1'b1);
        tick();
        lanes("ab", 1'b1, 1'b1, 5'h0A, 5'h0B);
        drive(6'd2, 5'h0C, 5'h0D, 1'b1, 1'b1);
        pops("cd", 1'b1, 1'b1);
        tick();
        lanes("cd", 1'b1, 1'b1, 5'h0C, 5'h0D);
        drive(6'd0, 5'h1F, 5'h1F, 1'b1, 1'b1);
        pops("empty_fifo", 1'b0, 1'b0);
        tick();
        lanes("drained", 1'b0, 1'b0, 5'h0, 5'h0);

        drive(6'd1, 5'h11, 5'h1F, 1'b1, 1'b1);
        pops("single", 1'b1, 1'b0);
        tick();
        lanes("single", 1'b1, 1'b0, 5'h11, 5'h0);

        drive(6'd2, 5'h0A, 5'h0B, 1'b1, 1'b1);
        pops("refill_ab", 1'b1, 1'b1);
        tick();
        lanes("refill_ab", 1'b1, 1'b1, 5'h0A, 5'h0B);
        drive(6'd1, 5'h0C, 5'h1E, 1'b1, 1'b0);
        pops("shift", 1'b1, 1'b0);
        tick();
        lanes("shift", 1'b1, 1'b1, 5'h0B, 5'h0C);

        drive(6'd3, 5'h0D, 5'h0E, 1'b0, 1'b1);
        pops("stall", 1'b0, 1'b0);
        tick();
        lanes("stall", 1'b1, 1'b1, 5'h0B, 5'h0C);
`ifdef F2O_DRAIN_PERF_EN
        chk("perf.stall", perf_stall_cnt_o, 32'd1);
        chk("perf.pop", perf_pop_cnt_o, 32'd8);
`endif

        flush_i = 1'b1;
        drive(6'd2, 5'h0E, 5'h0F, 1'b1, 1'b1);
        pops("flush", 1'b0, 1'b0);
        tick();
        lanes("flush", 1'b0, 1'b0, 5'h0, 5'h0);
        flush_i = 1'b0;
        drive(6'd2, 5'h0E, 5'h0F, 1'b1, 1'b1);
        pops("post_flush", 1'b1, 1'b1);
        tick();
        lanes("post_flush", 1'b1, 1'b1, 5'h0E, 5'h0F);

        rst = 1'b1;
        drive(6'd2, 5'h12, 5'h13, 1'b1, 1'b1);
        pops("mid_rst", 1'b0, 1'b0);
        tick();
        lanes("mid_rst", 1'b0, 1'b0, 5'h0, 5'h0);
        chk("mid_rst.d0", 32'(out_data0_o), 32'h0);
        chk("mid_rst.d1", 32'(out_data1_o), 32'h0);
        rst = 1'b0;
        drive(6'd1, 5'h14, 5'h15, 1'b1, 1'b1);
        pops("resume", 1'b1, 1'b0);
        tick();
        lanes("resume", 1'b1, 1'b0, 5'h14, 5'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
